// File: rtl/axis_arbiter.sv
// Packet-granular round-robin merge of S_INTF_NUM AXI4-Stream slaves onto one registered master;
// first beat out 2 cycles after request, one idle arbitration cycle between packets; granted slave stalls when the output register is full and not draining.
module axis_arbiter #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int S_INTF_NUM       = 2
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [AXIS_DATA_WIDTH*S_INTF_NUM-1:0]  s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8*S_INTF_NUM-1:0] s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH*S_INTF_NUM-1:0] s_axis_tuser,
  input  logic [S_INTF_NUM-1:0]                  s_axis_tvalid,
  output logic [S_INTF_NUM-1:0]                  s_axis_tready,
  input  logic [S_INTF_NUM-1:0]                  s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast
);
  localparam int KW = AXIS_DATA_WIDTH / 8;
  localparam int GW = (S_INTF_NUM > 1) ? $clog2(S_INTF_NUM) : 1;
  localparam int SW = GW + 1;
  localparam logic [SW-1:0] S_NUM    = SW'(S_INTF_NUM);
  localparam logic [GW-1:0] LAST_IDX = GW'(S_INTF_NUM - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               grant_q, grant_d;
  logic [GW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [KW-1:0]               tkeep_q, tkeep_d;
  logic [AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                        tlast_q, tlast_d;
  logic                        tvalid_q, tvalid_d;

  logic                        req_any;
  logic [GW-1:0]               pick;
  logic [SW-1:0]               sum;
  logic [AXIS_DATA_WIDTH-1:0]  sel_data;
  logic [KW-1:0]               sel_keep;
  logic [AXIS_TUSER_WIDTH-1:0] sel_user;
  logic                        sel_last;
  logic                        sel_valid;
  logic                        slot_rdy;
  logic                        grant_rdy;
  logic                        accept;

  // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    req_any = 1'b0;
    pick    = rr_ptr_q;
    sum     = '0;
    for (int k = S_INTF_NUM - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + SW'(k);
      if (sum >= S_NUM) sum = sum - S_NUM;
      if (s_axis_tvalid[sum[GW-1:0]]) begin
        req_any = 1'b1;
        pick    = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < S_INTF_NUM; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KW +: KW];
        sel_user  = s_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
        sel_last  = s_axis_tlast[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // Ready is masked during reset so no beat is consumed that the reset would discard.
  assign slot_rdy  = ~tvalid_q | m_axis_tready;
  assign grant_rdy = (state_q == BUSY) & ~areset & slot_rdy;
  assign accept    = grant_rdy & sel_valid;

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < S_INTF_NUM; i++) begin
      s_axis_tready[i] = grant_rdy & (grant_q == GW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d  = pick;
          rr_ptr_d = (pick == LAST_IDX) ? '0 : pick + GW'(1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      tdata_d  = sel_data;
      tkeep_d  = sel_keep;
      tuser_d  = sel_user;
      tlast_d  = sel_last;
      tvalid_d = 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_arbiter.sv
// Scoreboard bench for axis_arbiter: per-slave beat queues feed a driver, a monitor pops expected beats.
module tb_axis_arbiter;
  localparam int DW = 32;
  localparam int UW = 16;
  localparam int KW = DW / 8;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset;
  logic [DW*NS-1:0]  s_tdata;
  logic [KW*NS-1:0]  s_tkeep;
  logic [UW*NS-1:0]  s_tuser;
  logic [NS-1:0]     s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid, m_tready, m_tlast;

  axis_arbiter #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .S_INTF_NUM(NS)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  typedef struct packed {
    logic          bub;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t sq [NS][$];
  beat_t exp_q [$];
  int    out_cyc [$];
  int    cyc = 0;
  int    vld_cyc = -1;
  int    checks = 0;
  int    errors = 0;
  logic [NS-1:0] hs;
  logic [NS-1:0] shown_bub;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b      = '0;
    b.data = d;
    b.keep = k;
    b.user = d[UW-1:0] ^ 16'h5A5A;
    b.last = l;
    return b;
  endfunction

  task automatic send(input int i, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    sq[i].push_back(mk(d, k, l));
  endtask

  task automatic exp_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    exp_q.push_back(mk(d, k, l));
  endtask

  task automatic gap(input int i, input int n);
    beat_t b;
    b     = '0;
    b.bub = 1'b1;
    for (int g = 0; g < n; g++) sq[i].push_back(b);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic check_rst(input string nm);
    chk({nm, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({nm, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({nm, "_tdata"}, 64'(m_tdata), 64'd0);
    chk({nm, "_tkeep"}, 64'(m_tkeep), 64'd0);
    chk({nm, "_tuser"}, 64'(m_tuser), 64'd0);
    chk({nm, "_tlast"}, 64'(m_tlast), 64'd0);
  endtask

  task automatic wait_out(input int n, input string nm);
    for (int t = 0; t < 200 && out_cyc.size() < n; t++) begin
      @(negedge clk); #1;
    end
    chk(nm, 64'(out_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_drain(input string nm);
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
      @(negedge clk); #1;
    end
    repeat (4) @(negedge clk);
    #1;
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Driver: a beat advances after a handshake; bubble entries hold tvalid low for one cycle.
  initial begin
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tuser   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    shown_bub = '0;
    hs        = '0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if ((hs[i] || shown_bub[i]) && sq[i].size() > 0) void'(sq[i].pop_front());
        if (sq[i].size() > 0 && !sq[i][0].bub) begin
          s_tdata[i*DW +: DW] = sq[i][0].data;
          s_tkeep[i*KW +: KW] = sq[i][0].keep;
          s_tuser[i*UW +: UW] = sq[i][0].user;
          s_tlast[i]          = sq[i][0].last;
          s_tvalid[i]         = 1'b1;
          shown_bub[i]        = 1'b0;
        end else begin
          s_tvalid[i]  = 1'b0;
          s_tlast[i]   = 1'b0;
          shown_bub[i] = (sq[i].size() > 0);
        end
      end
    end
  end

  // Monitor: every accepted output beat is compared against the head of the expected queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (vld_cyc < 0 && s_tvalid != '0) vld_cyc = cyc;
      if (!areset && m_tvalid && m_tready) begin
        out_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %0h, no beat expected", m_tdata);
        end else begin
          e = exp_q.pop_front();
          if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== {e.data, e.keep, e.user, e.last}) begin
            errors++;
            $display("FAIL beat: got d=%0h k=%0h u=%0h l=%0b, required d=%0h k=%0h u=%0h l=%0b",
                     m_tdata, m_tkeep, m_tuser, m_tlast, e.data, e.keep, e.user, e.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    areset   = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_rst("reset");
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk); #1;
    check_rst("release");
    @(negedge clk); #1;
    chk("idle_tvalid", 64'(m_tvalid), 64'd0);

    // Simultaneous request right after reset: slave 0 first, one bubble, then slave 1.
    out_cyc.delete();
    send(0, 32'hB01, 4'hF, 1'b0); send(0, 32'hB02, 4'hF, 1'b1);
    send(1, 32'hC01, 4'hF, 1'b0); send(1, 32'hC02, 4'h3, 1'b1);
    exp_beat(32'hB01, 4'hF, 1'b0); exp_beat(32'hB02, 4'hF, 1'b1);
    exp_beat(32'hC01, 4'hF, 1'b0); exp_beat(32'hC02, 4'h3, 1'b1);
    wait_drain("simul_drain");
    chk("simul_back_to_back", (out_cyc.size() >= 4) ? 64'(out_cyc[1] - out_cyc[0]) : 64'd0, 64'd1);
    chk("simul_bubble", (out_cyc.size() >= 4) ? 64'(out_cyc[2] - out_cyc[1]) : 64'd0, 64'd2);

    // Single 3-beat packet from slave 1, first beat two cycles after valid.
    out_cyc.delete();
    vld_cyc = -1;
    send(1, 32'hA1, 4'hF, 1'b0); send(1, 32'hA2, 4'hF, 1'b0); send(1, 32'hA3, 4'hF, 1'b1);
    exp_beat(32'hA1, 4'hF, 1'b0); exp_beat(32'hA2, 4'hF, 1'b0); exp_beat(32'hA3, 4'hF, 1'b1);
    wait_drain("single_drain");
    chk("single_latency", (out_cyc.size() > 0) ? 64'(out_cyc[0] - vld_cyc) : 64'd0, 64'd2);
    chk("single_rate", (out_cyc.size() >= 3) ? 64'(out_cyc[2] - out_cyc[0]) : 64'd0, 64'd2);

    // Fairness: both slaves keep offering 1-beat packets, output alternates 0,1,...
    for (int p = 0; p < 4; p++) begin
      send(0, 32'hD000 + 32'(p), 4'hF, 1'b1);
      send(1, 32'hE000 + 32'(p), 4'hF, 1'b1);
      exp_beat(32'hD000 + 32'(p), 4'hF, 1'b1);
      exp_beat(32'hE000 + 32'(p), 4'hF, 1'b1);
    end
    wait_drain("fair_drain");

    // Backpressure: downstream stalls 5 cycles while beat E2 sits in the output register.
    out_cyc.delete();
    send(1, 32'hE1, 4'hF, 1'b0); send(1, 32'hE2, 4'hF, 1'b0);
    send(1, 32'hE3, 4'hF, 1'b0); send(1, 32'hE4, 4'h1, 1'b1);
    exp_beat(32'hE1, 4'hF, 1'b0); exp_beat(32'hE2, 4'hF, 1'b0);
    exp_beat(32'hE3, 4'hF, 1'b0); exp_beat(32'hE4, 4'h1, 1'b1);
    wait_out(1, "bp_first_beat");
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_tvalid", 64'(m_tvalid), 64'd1);
      chk("bp_tdata", 64'(m_tdata), 64'hE2);
      chk("bp_s_tready", 64'(s_tready), 64'd0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_drain("bp_drain");

    // Valid gap: slave 0 pauses 3 cycles mid-packet and still keeps the grant.
    send(0, 32'hF1, 4'hF, 1'b0); send(0, 32'hF2, 4'hF, 1'b0);
    gap(0, 3);
    send(0, 32'hF3, 4'hF, 1'b0); send(0, 32'hF4, 4'hF, 1'b1);
    send(1, 32'h71, 4'hF, 1'b1);
    exp_beat(32'hF1, 4'hF, 1'b0); exp_beat(32'hF2, 4'hF, 1'b0);
    exp_beat(32'hF3, 4'hF, 1'b0); exp_beat(32'hF4, 4'hF, 1'b1);
    exp_beat(32'h71, 4'hF, 1'b1);
    wait_drain("gap_drain");

    // Reset while beat 2 of a 4-beat packet is in the output register.
    out_cyc.delete();
    send(0, 32'h91, 4'hF, 1'b0); send(0, 32'h92, 4'hF, 1'b0);
    send(0, 32'h93, 4'hF, 1'b0); send(0, 32'h94, 4'hF, 1'b1);
    exp_beat(32'h91, 4'hF, 1'b0);
    wait_out(1, "rstmid_first_beat");
    @(posedge clk); #1;
    areset = 1'b1;
    @(negedge clk); #1;
    sq[0].delete();
    sq[1].delete();
    @(negedge clk); #1;
    check_rst("rstmid");
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_release_tvalid", 64'(m_tvalid), 64'd0);

    // rr_ptr was 1 before the reset; slave 0 must win the tie again.
    send(0, 32'h51, 4'hF, 1'b1);
    send(1, 32'h61, 4'hF, 1'b0); send(1, 32'h62, 4'hF, 1'b1);
    exp_beat(32'h51, 4'hF, 1'b1);
    exp_beat(32'h61, 4'hF, 1'b0); exp_beat(32'h62, 4'hF, 1'b1);
    wait_drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_arbiter.md
# axis_arbiter

Packet-granular round-robin AXI4-Stream arbiter that merges `S_INTF_NUM` slave streams into one master stream. It performs the reverse of `axis_broadcaster`, which fans one stream out to several. The arbiter sits where parallel per-port streams (for example broadcaster outputs after per-port processing) must rejoin one datapath. A grant is held for a whole packet, so beats from different slaves never interleave. The output is fully registered.

## Interface
- `AXIS_DATA_WIDTH`, 512: tdata width per stream.
- `AXIS_TUSER_WIDTH`, 256: tuser width per stream.
- `S_INTF_NUM`, 2: number of slave streams, 2..8.
- `aclk`  in  1: single clock for all logic.
- `areset`  in  1: synchronous, active-high reset, sampled on rising `aclk`.
- `s_axis_tdata`  in  AXIS_DATA_WIDTH*S_INTF_NUM: slave i data in slice [i*W +: W].
- `s_axis_tkeep`  in  AXIS_DATA_WIDTH/8*S_INTF_NUM: per-slave byte enables, sliced the same way.
- `s_axis_tuser`  in  AXIS_TUSER_WIDTH*S_INTF_NUM: per-slave sideband, sliced the same way.
- `s_axis_tvalid`  in  S_INTF_NUM: per-slave valid.
- `s_axis_tready`  out  S_INTF_NUM: per-slave ready.
- `s_axis_tlast`  in  S_INTF_NUM: per-slave end of packet.
- `m_axis_tdata`  out  AXIS_DATA_WIDTH: merged data.
- `m_axis_tkeep`  out  AXIS_DATA_WIDTH/8: merged byte enables.
- `m_axis_tuser`  out  AXIS_TUSER_WIDTH: merged sideband.
- `m_axis_tvalid`  out  1: output register valid.
- `m_axis_tready`  in  1: downstream ready.
- `m_axis_tlast`  out  1: merged end of packet.

## Operation
- **Storage.**
  - 2-state FSM: IDLE and BUSY.
  - Registered `grant` index, width clog2(S_INTF_NUM).
  - Round-robin pointer `rr_ptr`.
  - One output register stage holding data, keep, user, last and valid.
- **IDLE.**
  - If any `s_axis_tvalid` is high, select the first asserted index, searching `rr_ptr`, `rr_ptr`+1, … modulo S_INTF_NUM.
  - Register the result into `grant`, set `rr_ptr` to grant+1 mod S_INTF_NUM, and go to BUSY.
  - If no slave is valid, stay in IDLE.
  - All `s_axis_tready` are 0 in IDLE.
- **BUSY.**
  - `s_axis_tready[grant]` = ~`m_axis_tvalid` | `m_axis_tready`.
  - All other ready bits are 0.
  - A slave beat is accepted when `s_axis_tvalid[grant]` and `s_axis_tready[grant]` are both high. The accepted beat is loaded into the output register and `m_axis_tvalid` is set.
  - On an accepted beat with `s_axis_tlast[grant]`=1, return to IDLE.
- **Grant hold.**
  - The grant is held for the whole packet.
  - A `s_axis_tvalid[grant]` deassertion mid-packet does not release the grant. The arbiter waits indefinitely.
  - Other slaves' valids are ignored until the packet ends.
- **Output register.**
  - If `m_axis_tvalid` & `m_axis_tready` with no new load: clear `m_axis_tvalid`.
  - If a load and a drain occur in the same cycle: replace the contents, and `m_axis_tvalid` stays 1.
  - Contents are stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- **Sideband.** tkeep and tuser pass through unmodified. No width conversion is performed.

## Timing
- **Reset.** While `areset`=1, and on the cycle after it is released:
  - state = IDLE, `rr_ptr` = 0, `grant` = 0.
  - `m_axis_tvalid` = 0, `s_axis_tready` = all 0.
  - `m_axis_tdata`/`tkeep`/`tuser`/`tlast` = 0.
- **Arbitration latency.**
  - Slave valid first seen in IDLE at cycle N → grant registered at N+1 → first beat accepted at N+1 at the earliest → `m_axis_tvalid` high at N+2.
- **Throughput.**
  - With `m_axis_tready`=1 the arbiter sustains 1 beat/cycle within a packet.
  - There is one idle arbitration cycle between packets: last beat accepted at M, IDLE at M+1, next first beat accepted at M+2 at the earliest.
- **Reset mid-packet.**
  - The packet is abandoned and the output register is cleared.
  - The downstream sees a truncated packet with no tlast. This is accepted behaviour.
- **Single slave.** A single requesting slave is re-granted every packet, regardless of `rr_ptr`.

## Test plan
- **Single packet.**
  - Stimulus: slave 1 sends a 3-beat packet with tdata 0xA1, 0xA2, 0xA3 (tlast on beat 3), tkeep all ones, `m_axis_tready`=1.
  - Required response: the same 3 beats appear on m_axis, with the first beat 2 cycles after slave valid and tlast only on 0xA3.
- **Simultaneous request after reset.**
  - Stimulus: slaves 0 and 1 both present 2-beat packets in the same cycle.
  - Required response: slave 0's packet is output first, then slave 1's, with no interleaving and one bubble cycle between them.
- **Fairness.**
  - Stimulus: both slaves continuously offer 1-beat packets.
  - Required response: output source alternates 0,1,0,1 over 8 packets.
- **Backpressure.**
  - Stimulus: hold `m_axis_tready`=0 for 5 cycles mid-packet.
  - Required response: m_axis data is stable, `s_axis_tready[grant]`=0 while the register is full, and no beat is lost or duplicated.
- **Valid gap.**
  - Stimulus: slave 0 drops tvalid for 3 cycles mid-packet while slave 1 is valid.
  - Required response: slave 0 keeps the grant, and slave 1 is served only after slave 0's tlast.
- **Reset mid-packet.**
  - Stimulus: assert `areset` on beat 2 of a 4-beat packet.
  - Required response: the next cycle shows `m_axis_tvalid`=0 and all ready bits 0. After release, a new packet from slave 1 is served normally with `rr_ptr` starting at 0.
